// File: rtl/line_trace_pkg.sv
// Shared types and constants for the line-tracing motor controller.
package line_trace_pkg;

  // Controller states
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FWD,
    ST_TURN_L,
    ST_TURN_R,
    ST_SHARP_L,
    ST_SHARP_R,
    ST_SEARCH,
    ST_AVOID,
    ST_HALT
  } state_t;

  // Wheel direction encodings
  localparam logic [1:0] DIR_FWD   = 2'b10;
  localparam logic [1:0] DIR_REV   = 2'b01;
  localparam logic [1:0] DIR_BRAKE = 2'b00;

  // Direction LED codes (one-hot)
  localparam logic [3:0] LED_FWD   = 4'b1000;
  localparam logic [3:0] LED_LEFT  = 4'b0100;
  localparam logic [3:0] LED_RIGHT = 4'b0010;
  localparam logic [3:0] LED_STOP  = 4'b0001;

  // Duty table expressed for an 8-bit PWM counter
  localparam int unsigned DUTY_STOP   = 32'd0;
  localparam int unsigned DUTY_SLOW   = 32'd150;
  localparam int unsigned DUTY_CRUISE = 32'd220;
  localparam int unsigned DUTY_FAST   = 32'd250;

  // Rescale an 8-bit duty value to a PWM counter of another width
  function automatic int unsigned scale_duty(input int unsigned duty8, input int unsigned width);
    int unsigned scaled;
    if (width >= 32'd8) begin
      scaled = duty8 << (width - 32'd8);
    end else begin
      scaled = duty8 >> (32'd8 - width);
    end
    return scaled;
  endfunction

endpackage

// File: rtl/line_trace_ctrl_pwm_gen.sv
// Shared free-running PWM counter with two wrap-latched duty comparators.
// A new duty is only taken when the counter rolls over, so every period is whole.
module line_trace_ctrl_pwm_gen #(
  parameter int PWM_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PWM_W-1:0] duty_a,
  input  logic [PWM_W-1:0] duty_b,
  output logic             pwm_a,
  output logic             pwm_b
);

  logic [PWM_W-1:0] cnt_r;
  logic [PWM_W-1:0] duty_a_r;
  logic [PWM_W-1:0] duty_b_r;
  logic             pwm_a_r;
  logic             pwm_b_r;

  // Counter, period-boundary duty capture and registered compare
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r    <= '0;
      duty_a_r <= '0;
      duty_b_r <= '0;
      pwm_a_r  <= 1'b0;
      pwm_b_r  <= 1'b0;
    end else begin
      cnt_r <= cnt_r + PWM_W'(1);
      if (cnt_r == {PWM_W{1'b1}}) begin
        duty_a_r <= duty_a;
        duty_b_r <= duty_b;
      end else begin
        duty_a_r <= duty_a_r;
        duty_b_r <= duty_b_r;
      end
      pwm_a_r <= (cnt_r < duty_a_r);
      pwm_b_r <= (cnt_r < duty_b_r);
    end
  end

  assign pwm_a = pwm_a_r;
  assign pwm_b = pwm_b_r;

endmodule

// File: rtl/line_trace_ctrl.sv
// Line-following robot controller: sensor debounce, position decode,
// motion FSM with obstacle override, and two-wheel PWM drive.
module line_trace_ctrl
  import line_trace_pkg::*;
#(
  parameter int NUM_SENS  = 5,
  parameter int PWM_W     = 8,
  parameter int DEB_CYC   = 16,
  parameter int LOST_CYC  = 2000000,
  parameter int AVOID_CYC = 1000000
) (
  input  logic                clk,
  input  logic                CR,
  input  logic                En_Tracing,
  input  logic [1:0]          SpeedSel,
  input  logic [NUM_SENS-1:0] PathDectSignal,
  input  logic [1:0]          AvoidSignal,
  output logic [3:0]          Led_Direction,
  output logic                Speed_Wheel_1,
  output logic                Speed_Wheel_2,
  output logic [1:0]          Control_Wheel_1,
  output logic [1:0]          Control_Wheel_2
);

  localparam int C       = NUM_SENS / 2;
  localparam int DEB_W   = $clog2(DEB_CYC + 1);
  localparam int LOST_W  = $clog2(LOST_CYC + 1);
  localparam int AVOID_W = $clog2(AVOID_CYC + 1);
  localparam logic [PWM_W-1:0] D_SLOW   = PWM_W'(scale_duty(DUTY_SLOW, PWM_W));
  localparam logic [PWM_W-1:0] D_CRUISE = PWM_W'(scale_duty(DUTY_CRUISE, PWM_W));
  localparam logic [PWM_W-1:0] D_FAST   = PWM_W'(scale_duty(DUTY_FAST, PWM_W));
  localparam logic [NUM_SENS-1:0] OUTER_L = {1'b1, {(NUM_SENS-1){1'b0}}};
  localparam logic [NUM_SENS-1:0] OUTER_R = {{(NUM_SENS-1){1'b0}}, 1'b1};

  logic [NUM_SENS-1:0] filt_s;
  state_t              state_r, next_s, pos_s;
  logic [LOST_W-1:0]   lost_cnt_r;
  logic [AVOID_W-1:0]  avoid_cnt_r;
  logic                last_left_r;
  logic [PWM_W-1:0]    lvl_s, slow_s, duty1_s, duty2_s, duty1_r, duty2_r;
  logic [3:0]          led_s, led_r;
  logic [1:0]          cw1_s, cw2_s, cw1_r, cw2_r;
  logic                side_l_s, side_r_s;

  // Per-sensor debounce: a new level is accepted after DEB_CYC steady samples
  for (genvar i = 0; i < NUM_SENS; i++) begin : g_deb
    logic [DEB_W-1:0] cnt_r;
    logic             bit_r;
    // Count consecutive samples that disagree with the filtered level
    always_ff @(posedge clk) begin
      if (CR) begin
        cnt_r <= '0;
        bit_r <= 1'b0;
      end else if (PathDectSignal[i] == bit_r) begin
        cnt_r <= '0;
      end else if (cnt_r == DEB_W'(DEB_CYC - 1)) begin
        cnt_r <= '0;
        bit_r <= PathDectSignal[i];
      end else begin
        cnt_r <= cnt_r + DEB_W'(1);
      end
    end
    assign filt_s[i] = bit_r;
  end

  assign side_l_s = |filt_s[NUM_SENS-1:C+1];
  assign side_r_s = |filt_s[C-1:0];

  // Map the filtered sensor pattern to the motion state it asks for
  always_comb begin
    pos_s = ST_FWD;
    if (filt_s[C] || (side_l_s == side_r_s)) begin
      pos_s = ST_FWD;
    end else if (side_l_s) begin
      if (filt_s == OUTER_L) pos_s = ST_SHARP_L;
      else                   pos_s = ST_TURN_L;
    end else begin
      if (filt_s == OUTER_R) pos_s = ST_SHARP_R;
      else                   pos_s = ST_TURN_R;
    end
  end

  // Speed level to duty; inner-wheel duty is the slow level unless stopped
  always_comb begin
    lvl_s = '0;
    case (SpeedSel)
      2'd1:    lvl_s = D_SLOW;
      2'd2:    lvl_s = D_CRUISE;
      2'd3:    lvl_s = D_FAST;
      default: lvl_s = '0;
    endcase
    if (SpeedSel == 2'd0) slow_s = '0;
    else                  slow_s = D_SLOW;
  end

  // Next state: enable first, then obstacle override, then line decode
  always_comb begin
    next_s = state_r;
    if (!En_Tracing) begin
      next_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: next_s = ST_FWD;
        ST_HALT: next_s = ST_HALT;
        ST_AVOID: begin
          if (avoid_cnt_r == AVOID_W'(AVOID_CYC - 1)) next_s = ST_SEARCH;
          else                                        next_s = ST_AVOID;
        end
        default: begin
          if (AvoidSignal == 2'b11)      next_s = ST_AVOID;
          else if (AvoidSignal == 2'b10) next_s = ST_TURN_R;
          else if (AvoidSignal == 2'b01) next_s = ST_TURN_L;
          else if (filt_s == '0) begin
            if ((state_r == ST_SEARCH) && (lost_cnt_r == LOST_W'(LOST_CYC - 1))) next_s = ST_HALT;
            else                                                                  next_s = ST_SEARCH;
          end else begin
            next_s = pos_s;
          end
        end
      endcase
    end
  end

  // Drive pattern for the current state; registered below
  always_comb begin
    led_s = LED_STOP; cw1_s = DIR_BRAKE; cw2_s = DIR_BRAKE; duty1_s = '0; duty2_s = '0;
    case (state_r)
      ST_FWD:     begin led_s = LED_FWD;   cw1_s = DIR_FWD; cw2_s = DIR_FWD; duty1_s = lvl_s;  duty2_s = lvl_s;  end
      ST_TURN_L:  begin led_s = LED_LEFT;  cw1_s = DIR_FWD; cw2_s = DIR_FWD; duty1_s = slow_s; duty2_s = lvl_s;  end
      ST_TURN_R:  begin led_s = LED_RIGHT; cw1_s = DIR_FWD; cw2_s = DIR_FWD; duty1_s = lvl_s;  duty2_s = slow_s; end
      ST_SHARP_L: begin led_s = LED_LEFT;  cw1_s = DIR_REV; cw2_s = DIR_FWD; duty1_s = slow_s; duty2_s = lvl_s;  end
      ST_SHARP_R: begin led_s = LED_RIGHT; cw1_s = DIR_FWD; cw2_s = DIR_REV; duty1_s = lvl_s;  duty2_s = slow_s; end
      ST_AVOID:   begin led_s = LED_STOP;  cw1_s = DIR_REV; cw2_s = DIR_REV; duty1_s = slow_s; duty2_s = slow_s; end
      ST_SEARCH: begin
        // Pivot on the inner wheel toward the side the line was last seen
        if (last_left_r) begin
          led_s = LED_LEFT;  cw1_s = DIR_BRAKE; cw2_s = DIR_FWD;   duty1_s = '0;     duty2_s = slow_s;
        end else begin
          led_s = LED_RIGHT; cw1_s = DIR_FWD;   cw2_s = DIR_BRAKE; duty1_s = slow_s; duty2_s = '0;
        end
      end
      default: begin led_s = LED_STOP; cw1_s = DIR_BRAKE; cw2_s = DIR_BRAKE; duty1_s = '0; duty2_s = '0; end
    endcase
  end

  // State register, lost/avoid timers, last turn memory and output registers
  always_ff @(posedge clk) begin
    if (CR) begin
      state_r     <= ST_IDLE;
      lost_cnt_r  <= '0;
      avoid_cnt_r <= '0;
      last_left_r <= 1'b0;
      led_r       <= LED_STOP;
      cw1_r       <= DIR_BRAKE;
      cw2_r       <= DIR_BRAKE;
      duty1_r     <= '0;
      duty2_r     <= '0;
    end else begin
      state_r     <= next_s;
      lost_cnt_r  <= ((state_r == ST_SEARCH) && (next_s == ST_SEARCH)) ? lost_cnt_r + LOST_W'(1) : '0;
      avoid_cnt_r <= ((state_r == ST_AVOID) && (next_s == ST_AVOID)) ? avoid_cnt_r + AVOID_W'(1) : '0;
      if ((next_s == ST_TURN_L) || (next_s == ST_SHARP_L))      last_left_r <= 1'b1;
      else if ((next_s == ST_TURN_R) || (next_s == ST_SHARP_R)) last_left_r <= 1'b0;
      else                                                      last_left_r <= last_left_r;
      led_r   <= led_s;
      cw1_r   <= cw1_s;
      cw2_r   <= cw2_s;
      duty1_r <= duty1_s;
      duty2_r <= duty2_s;
    end
  end

  line_trace_ctrl_pwm_gen #(.PWM_W(PWM_W)) u_pwm_gen (
    .clk    (clk),
    .rst    (CR),
    .duty_a (duty1_r),
    .duty_b (duty2_r),
    .pwm_a  (Speed_Wheel_1),
    .pwm_b  (Speed_Wheel_2)
  );

  assign Led_Direction   = led_r;
  assign Control_Wheel_1 = cw1_r;
  assign Control_Wheel_2 = cw2_r;

endmodule

// File: tb/tb_line_trace_ctrl.sv
// Bench for line_trace_ctrl: directed scenarios plus random stimulus, every
// clock compared against a behavioural reference model.
module tb_line_trace_ctrl;

  localparam int NS = 5, PW = 8, DEB = 4, LOST = 100, AVC = 50;

  logic          clk = 1'b0;
  logic          CR, En_Tracing;
  logic [1:0]    SpeedSel, AvoidSignal;
  logic [NS-1:0] PathDectSignal;
  logic [3:0]    Led_Direction;
  logic          Speed_Wheel_1, Speed_Wheel_2;
  logic [1:0]    Control_Wheel_1, Control_Wheel_2;

  int n_checks = 0;
  int n_fail   = 0;

  line_trace_ctrl #(.NUM_SENS(NS), .PWM_W(PW), .DEB_CYC(DEB), .LOST_CYC(LOST), .AVOID_CYC(AVC)) dut (
    .clk(clk), .CR(CR), .En_Tracing(En_Tracing), .SpeedSel(SpeedSel),
    .PathDectSignal(PathDectSignal), .AvoidSignal(AvoidSignal),
    .Led_Direction(Led_Direction), .Speed_Wheel_1(Speed_Wheel_1), .Speed_Wheel_2(Speed_Wheel_2),
    .Control_Wheel_1(Control_Wheel_1), .Control_Wheel_2(Control_Wheel_2));

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef enum int {M_IDLE, M_FWD, M_TL, M_TR, M_SL, M_SR, M_SEARCH, M_AVOID, M_HALT} mstate_t;
  mstate_t       ms;
  logic [NS-1:0] m_filt;
  logic [DEB-1:0] m_hist [NS];
  int            avoid_rem, lost_rem, m_cnt, m_duty1, m_duty2, m_tgt1, m_tgt2;
  bit            m_left;
  logic [3:0]    e_led;
  logic [1:0]    e_cw1, e_cw2;
  logic          e_sw1, e_sw2;

  function automatic int duty_of(input logic [1:0] lvl);
    case (lvl)
      2'd1: return 150;
      2'd2: return 220;
      2'd3: return 250;
      default: return 0;
    endcase
  endfunction

  function automatic mstate_t decode(input logic [NS-1:0] f);
    int c, nl, nr;
    c = NS / 2; nl = 0; nr = 0;
    for (int i = 0; i < NS; i++) begin
      if (f[i] && i > c) nl++;
      if (f[i] && i < c) nr++;
    end
    if (f[c] || (nl > 0 && nr > 0) || (nl == 0 && nr == 0)) return M_FWD;
    if (nl > 0) return (nl == 1 && f[NS-1]) ? M_SL : M_TL;
    return (nr == 1 && f[0]) ? M_SR : M_TR;
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge
  task automatic model_edge();
    int lvl, slow;
    mstate_t nx;
    if (CR) begin
      ms = M_IDLE; m_filt = '0; avoid_rem = 0; lost_rem = 0; m_left = 0;
      for (int i = 0; i < NS; i++) m_hist[i] = '0;
      m_cnt = 0; m_duty1 = 0; m_duty2 = 0; m_tgt1 = 0; m_tgt2 = 0;
      e_led = 4'b0001; e_cw1 = 2'b00; e_cw2 = 2'b00; e_sw1 = 1'b0; e_sw2 = 1'b0;
      return;
    end
    // PWM: whole periods, duty taken from the drive target at each rollover
    e_sw1 = (m_cnt < m_duty1);
    e_sw2 = (m_cnt < m_duty2);
    if (m_cnt == 255) begin m_cnt = 0; m_duty1 = m_tgt1; m_duty2 = m_tgt2; end
    else m_cnt++;
    // Drive pattern of the state held before this edge
    lvl = duty_of(SpeedSel);
    slow = (SpeedSel == 2'd0) ? 0 : 150;
    case (ms)
      M_FWD:    begin e_led = 4'b1000; e_cw1 = 2'b10; e_cw2 = 2'b10; m_tgt1 = lvl;  m_tgt2 = lvl;  end
      M_TL:     begin e_led = 4'b0100; e_cw1 = 2'b10; e_cw2 = 2'b10; m_tgt1 = slow; m_tgt2 = lvl;  end
      M_TR:     begin e_led = 4'b0010; e_cw1 = 2'b10; e_cw2 = 2'b10; m_tgt1 = lvl;  m_tgt2 = slow; end
      M_SL:     begin e_led = 4'b0100; e_cw1 = 2'b01; e_cw2 = 2'b10; m_tgt1 = slow; m_tgt2 = lvl;  end
      M_SR:     begin e_led = 4'b0010; e_cw1 = 2'b10; e_cw2 = 2'b01; m_tgt1 = lvl;  m_tgt2 = slow; end
      M_AVOID:  begin e_led = 4'b0001; e_cw1 = 2'b01; e_cw2 = 2'b01; m_tgt1 = slow; m_tgt2 = slow; end
      M_SEARCH: begin
        if (m_left) begin e_led = 4'b0100; e_cw1 = 2'b00; e_cw2 = 2'b10; m_tgt1 = 0;    m_tgt2 = slow; end
        else        begin e_led = 4'b0010; e_cw1 = 2'b10; e_cw2 = 2'b00; m_tgt1 = slow; m_tgt2 = 0;    end
      end
      default:  begin e_led = 4'b0001; e_cw1 = 2'b00; e_cw2 = 2'b00; m_tgt1 = 0;    m_tgt2 = 0;    end
    endcase
    // State progression
    nx = ms;
    if (!En_Tracing) nx = M_IDLE;
    else if (ms == M_IDLE) nx = M_FWD;
    else if (ms == M_HALT) nx = M_HALT;
    else if (ms == M_AVOID) begin
      avoid_rem--;
      if (avoid_rem == 0) begin nx = M_SEARCH; lost_rem = LOST; end
    end else if (AvoidSignal == 2'b11) begin nx = M_AVOID; avoid_rem = AVC; end
    else if (AvoidSignal == 2'b10) nx = M_TR;
    else if (AvoidSignal == 2'b01) nx = M_TL;
    else if (m_filt == '0) begin
      if (ms != M_SEARCH) begin nx = M_SEARCH; lost_rem = LOST; end
      else begin lost_rem--; if (lost_rem == 0) nx = M_HALT; end
    end else nx = decode(m_filt);
    if (nx == M_TL || nx == M_SL) m_left = 1;
    if (nx == M_TR || nx == M_SR) m_left = 0;
    ms = nx;
    // Debounce: accept a level once the last DEB samples all disagree with the filtered one
    for (int i = 0; i < NS; i++) begin
      m_hist[i] = {m_hist[i][DEB-2:0], PathDectSignal[i]};
      if (m_hist[i] == {DEB{~m_filt[i]}}) m_filt[i] = PathDectSignal[i];
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("model_led", 32'(Led_Direction), 32'(e_led));
    chk("model_cw1", 32'(Control_Wheel_1), 32'(e_cw1));
    chk("model_cw2", 32'(Control_Wheel_2), 32'(e_cw2));
    chk("model_sw1", 32'(Speed_Wheel_1), 32'(e_sw1));
    chk("model_sw2", 32'(Speed_Wheel_2), 32'(e_sw2));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_count(input int n, output int h1, output int h2);
    h1 = 0; h2 = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      h1 += Speed_Wheel_1 ? 1 : 0;
      h2 += Speed_Wheel_2 ? 1 : 0;
    end
  endtask

  int h1, h2, run, bad, last_run, hold;
  logic [NS-1:0] pat_tbl [8];

  initial begin
    CR = 1'b1; En_Tracing = 1'b0; SpeedSel = 2'd0; AvoidSignal = 2'b00; PathDectSignal = '0;
    ticks(2);
    chk("rst_led", 32'(Led_Direction), 32'h1);
    chk("rst_cw1", 32'(Control_Wheel_1), 32'h0);
    chk("rst_sw1", 32'(Speed_Wheel_1), 32'h0);

    // Straight tracking at cruise speed
    CR = 1'b0; En_Tracing = 1'b1; SpeedSel = 2'd2; PathDectSignal = 5'b00100;
    ticks(10);
    chk("fwd_led", 32'(Led_Direction), 32'h8);
    chk("fwd_cw1", 32'(Control_Wheel_1), 32'h2);
    chk("fwd_cw2", 32'(Control_Wheel_2), 32'h2);
    ticks(300);
    run_count(256, h1, h2);
    chk("fwd_duty1", 32'(h1), 32'd220);
    chk("fwd_duty2", 32'(h2), 32'd220);

    // Short glitch is filtered out, a long one turns left
    PathDectSignal = 5'b01000; ticks(3);
    PathDectSignal = 5'b00100; ticks(10);
    chk("deb_glitch_led", 32'(Led_Direction), 32'h8);
    PathDectSignal = 5'b01000; ticks(5);
    chk("deb_lat5_led", 32'(Led_Direction), 32'h8);
    ticks(1);
    chk("deb_lat6_led", 32'(Led_Direction), 32'h4);
    ticks(300);
    run_count(256, h1, h2);
    chk("turnl_duty1", 32'(h1), 32'd150);
    chk("turnl_duty2", 32'(h2), 32'd220);

    // Sharp left, line lost, search then halt
    PathDectSignal = 5'b10000; ticks(6);
    chk("sharpl_cw1", 32'(Control_Wheel_1), 32'h1);
    chk("sharpl_cw2", 32'(Control_Wheel_2), 32'h2);
    PathDectSignal = 5'b00000; ticks(6);
    chk("search_led", 32'(Led_Direction), 32'h4);
    ticks(99);
    chk("search_end_led", 32'(Led_Direction), 32'h4);
    ticks(1);
    chk("halt_led", 32'(Led_Direction), 32'h1);
    chk("halt_cw2", 32'(Control_Wheel_2), 32'h0);

    // Leave halt through disable, then restart on the line
    En_Tracing = 1'b0; ticks(2);
    En_Tracing = 1'b1; PathDectSignal = 5'b00100; ticks(12);
    chk("restart_led", 32'(Led_Direction), 32'h8);

    // Obstacle on both sides: reverse for the avoid window, toggles ignored
    AvoidSignal = 2'b11; ticks(1);
    AvoidSignal = 2'b00; ticks(1);
    chk("avoid_cw1", 32'(Control_Wheel_1), 32'h1);
    chk("avoid_cw2", 32'(Control_Wheel_2), 32'h1);
    for (int i = 3; i <= 40; i++) begin AvoidSignal = 2'($urandom); tick(); end
    AvoidSignal = 2'b00; ticks(11);
    chk("avoid_last_cw1", 32'(Control_Wheel_1), 32'h1);
    ticks(1);
    chk("avoid_exit_cw1", 32'(Control_Wheel_1), 32'h0);
    chk("avoid_exit_led", 32'(Led_Direction), 32'h4);
    ticks(1);
    chk("avoid_back_led", 32'(Led_Direction), 32'h8);

    // Speed change mid-period: every high pulse is a whole old or new duty
    ticks(300);
    for (int i = 0; i < 300 && Speed_Wheel_1; i++) tick();
    chk("pwm_low_found", 32'(Speed_Wheel_1), 32'h0);
    run = 0; bad = 0; last_run = 0;
    for (int i = 0; i < 700; i++) begin
      if (i == 100) SpeedSel = 2'd3;
      tick();
      if (Speed_Wheel_1) run++;
      else begin
        if (run != 0) begin
          if (run != 220 && run != 250) bad++;
          last_run = run;
        end
        run = 0;
      end
    end
    chk("pwm_bad_runs", 32'(bad), 32'd0);
    chk("pwm_new_run", 32'(last_run), 32'd250);

    // Reset during avoid, and disable from forward
    AvoidSignal = 2'b11; ticks(1);
    AvoidSignal = 2'b00; ticks(9);
    CR = 1'b1; ticks(1);
    chk("cr_led", 32'(Led_Direction), 32'h1);
    chk("cr_cw1", 32'(Control_Wheel_1), 32'h0);
    chk("cr_cw2", 32'(Control_Wheel_2), 32'h0);
    chk("cr_sw2", 32'(Speed_Wheel_2), 32'h0);
    CR = 1'b0; ticks(12);
    chk("post_cr_led", 32'(Led_Direction), 32'h8);
    En_Tracing = 1'b0; ticks(2);
    chk("dis_led", 32'(Led_Direction), 32'h1);
    chk("dis_cw1", 32'(Control_Wheel_1), 32'h0);
    En_Tracing = 1'b1;

    // Random stimulus against the model
    pat_tbl[0] = 5'b00100; pat_tbl[1] = 5'b01000; pat_tbl[2] = 5'b00010; pat_tbl[3] = 5'b10000;
    pat_tbl[4] = 5'b00001; pat_tbl[5] = 5'b00000; pat_tbl[6] = 5'b11000; pat_tbl[7] = 5'b10001;
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 3) == 0) PathDectSignal = NS'($urandom);
      else PathDectSignal = pat_tbl[$urandom_range(0, 7)];
      AvoidSignal = ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'b00;
      if ($urandom_range(0, 7) == 0) SpeedSel = 2'($urandom);
      En_Tracing = ($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1;
      CR = ($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0;
      hold = $urandom_range(1, 8);
      ticks(hold);
      CR = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
